// File: rtl/gcd_stein.sv
`default_nettype none
// ============================================================================
//  Module      : tzn32 / gcd_stein
//  Description : tzn32 counts trailing zeros of a WIDTH-bit word (returns
//                WIDTH for an all-zero word).
//                gcd_stein is an iterative binary (Stein) GCD engine with a
//                valid/ready request interface and a valid/ready response
//                interface. One operation is in flight at a time.
//  Ports (gcd_stein):
//    clock    in   rising-edge clock
//    reset_n  in   asynchronous active-low reset
//    valid_i  in   request valid
//    ready_o  out  engine can accept a request (IDLE)
//    a_i,b_i  in   unsigned operands
//    valid_o  out  result valid (DONE)
//    ready_i  in   downstream accepts result
//    gcd_o    out  gcd(a_i, b_i)
//  Revision    : 1.0 - initial release
// ============================================================================

module tzn32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       x_i,
  output logic [$clog2(WIDTH):0] tz_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Scan from MSB to LSB so the lowest set bit wins the final assignment.
  always_comb begin
    tz_o = CW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x_i[i]) tz_o = CW'(i);
    end
  end

endmodule

module gcd_stein #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] gcd_o
);

  localparam int KW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_LOOP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;

  logic [KW-1:0]    tz_a;
  logic [KW-1:0]    tz_b;
  logic [WIDTH-1:0] b_odd;
  logic [WIDTH-1:0] min_ab;
  logic [WIDTH-1:0] max_ab;
  logic [WIDTH-1:0] diff_ab;
  logic             any_zero;

  tzn32 #(.WIDTH(WIDTH)) u_tz_a (.x_i(a_q), .tz_o(tz_a));
  tzn32 #(.WIDTH(WIDTH)) u_tz_b (.x_i(b_q), .tz_o(tz_b));

  // LOOP datapath: a_q is already odd, b_q is nonzero; strip b's factors of
  // two, then keep the smaller value and the (even or zero) difference.
  always_comb begin
    b_odd    = b_q >> tz_b;
    min_ab   = (a_q < b_odd) ? a_q : b_odd;
    max_ab   = (a_q < b_odd) ? b_odd : a_q;
    diff_ab  = max_ab - min_ab;
    any_zero = (a_q == '0) || (b_q == '0);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      gcd_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      gcd_q   <= gcd_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (valid_i) state_d = S_INIT;
      S_INIT: state_d = any_zero ? S_DONE : S_LOOP;
      S_LOOP: if (diff_ab == '0) state_d = S_DONE;
      S_DONE: if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    k_d   = k_q;
    gcd_d = gcd_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          a_d = a_i;
          b_d = b_i;
        end
      end
      S_INIT: begin
        if (any_zero) begin
          // With at least one operand zero, OR yields the other operand
          // (or zero when both are zero).
          gcd_d = a_q | b_q;
        end else begin
          k_d = (tz_a < tz_b) ? tz_a : tz_b;
          a_d = a_q >> tz_a;
        end
      end
      S_LOOP: begin
        a_d = min_ab;
        b_d = diff_ab;
        // Restore the common power of two removed at INIT.
        if (diff_ab == '0) gcd_d = min_ab << k_q;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    ready_o = (state_q == S_IDLE);
    valid_o = (state_q == S_DONE);
    gcd_o   = gcd_q;
  end

endmodule
`default_nettype wire
